regfile_bypass: RTL
===================

REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i uses slice i.
REQ-008 SHALL have port rd_data  output  NUM_RD*DATA_W  packed read data, combinational.
REQ-009 SHALL have port rd_busy  output  NUM_RD  per-port flag: the addressed register has a pending write.
REQ-010 SHALL have port wr_en  input  1  writeback strobe.
REQ-011 SHALL have port wr_addr  input  ADDR_W  writeback destination.
REQ-012 SHALL have port wr_data  input  DATA_W  writeback value.
REQ-013 SHALL have port iss_en  input  1  issue strobe; marks iss_addr as pending.
REQ-014 SHALL have port iss_addr  input  ADDR_W  destination of the issuing instruction.
REQ-015 SHALL have port flush  input  1  synchronous clear of all pending marks.
REQ-016 SHALL have port busy_cnt  output  ADDR_W+1  registered count of pending registers.

Function
REQ-017 SHALL store DEPTH words of DATA_W bits; a write with wr_en=1 updates mem[wr_addr] at the clock edge.
REQ-018 SHALL, when ZERO_REG=1, ignore writes and issues to address 0, always read 0 from it, and never report it busy.
REQ-019 SHALL bypass: if wr_en=1, wr_addr==rd_addr[i], and the address is writable, rd_data[i]=wr_data in the same cycle; otherwise rd_data[i]=mem[rd_addr[i]].
REQ-020 SHALL keep one busy bit per register: iss_en sets busy[iss_addr]; wr_en clears busy[wr_addr].
REQ-021 SHALL, when iss_en and wr_en target the same address in one cycle, leave busy set (younger issue wins), while still writing data.
REQ-022 SHALL drive rd_busy[i] = busy[rd_addr[i]] AND NOT (wr_en AND wr_addr==rd_addr[i]).
REQ-023 SHALL, on flush=1, clear all busy bits at the edge, overriding a simultaneous iss_en; data writes in that cycle still occur.
REQ-024 SHALL update busy_cnt one cycle after the busy bits change, equal to the population count of busy; range 0..DEPTH, no wrap.
REQ-025 SHALL give identical results to all read ports addressing the same register in the same cycle.
REQ-026 SHALL treat an issue to an already-busy register as a no-op on busy (no count double-increment).

Reset
REQ-027 SHALL, on rst_n=0, immediately clear all registers to 0, all busy bits to 0 and busy_cnt to 0, independent of clk.
REQ-028 SHALL ignore wr_en, iss_en and flush while rst_n=0; operation resumes on the first rising clk edge after deassertion.

Structure
REQ-029 SHALL place default DATA_W/ADDR_W constants and a function computing the read-port slice offset in the shared CPU package.
REQ-030 SHALL implement busy tracking and busy_cnt in one sub-module, regfile_scoreboard; storage and bypass muxes stay in the top.

Verification
REQ-031 SHALL cover: reset, then read all 32 addresses -> every rd_data=0, rd_busy=0, busy_cnt=0.
REQ-032 SHALL cover: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF with rd_addr[0]=5 in the same cycle -> rd_data[0]=0xDEADBEEF combinationally, and still 0xDEADBEEF the next cycle.
REQ-033 SHALL cover: write 0x1234 to address 0 (ZERO_REG=1) -> rd_data=0 on all ports, rd_busy=0.
REQ-034 SHALL cover: iss_en to 7 at cycle 1 -> rd_busy=1 for address 7 from cycle 2 and busy_cnt=1 from cycle 3; wr_en to 7 with 0xA5 at cycle 4 -> rd_busy=0 during cycle 4, busy_cnt=0 at cycle 6.
REQ-035 SHALL cover: iss_en and wr_en both to 9 in one cycle -> mem[9] updated, busy[9]=1; then flush with iss_en to 3 -> busy_cnt reaches 0, address 3 not busy.
REQ-036 SHALL cover: rst_n asserted mid-cycle with 4 registers busy and nonzero data -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/regfile_bypass_pkg.sv
// Shared CPU package for the register file slice.
// Holds the default data/address widths used by the register file and a
// helper that locates a read port's slice inside the packed address/data
// buses.
// Contents:
//   DEFAULT_DATA_W : default register width in bits
//   DEFAULT_ADDR_W : default register address width
//   sliceOffset()  : bit offset of port portIdx in a bus of width-bit slices
package regfile_bypass_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    // Port i occupies bits [i*width +: width] of every packed per-port bus.
    function automatic int sliceOffset(input int portIdx, input int width);
        return portIdx * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write tracker for the register file.
// One busy bit per register: an issue marks its destination pending, a
// writeback clears it, and a flush clears everything. The registered
// busy_cnt follows the population count of the busy bits one cycle later.
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   rd_addr           : packed read addresses, NUM_RD slices of ADDR_W
//   rd_busy           : per read port, addressed register is still pending
//   wr_en, wr_addr    : writeback strobe and destination
//   iss_en, iss_addr  : issue strobe and destination
//   flush             : synchronous clear of all pending marks
//   busy_cnt          : registered count of pending registers
module regfile_scoreboard
    import regfile_bypass_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]  r_busyBits;
    logic [ADDR_W:0]   r_busyCnt;
    logic [ADDR_W:0]   w_popCount;
    logic [NUM_RD-1:0] w_rdBusy;
    logic              w_issOk;

    // Issues to the hardwired zero register never mark it pending.
    assign w_issOk = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

    // The issue update is written after the writeback clear so that an
    // issue and a writeback to the same register leave it pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busyBits <= '0;
            r_busyCnt  <= '0;
        end else begin
            r_busyCnt <= w_popCount;
            if (flush) begin
                r_busyBits <= '0;
            end else begin
                if (wr_en) begin
                    r_busyBits[wr_addr] <= 1'b0;
                end
                if (w_issOk) begin
                    r_busyBits[iss_addr] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_popCount = '0;
        for (int j = 0; j < DEPTH; j++) begin
            w_popCount = w_popCount + (ADDR_W + 1)'(r_busyBits[j]);
        end
    end

    // A writeback landing this cycle already resolves the hazard for readers.
    always_comb begin
        w_rdBusy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_rdBusy[i] = r_busyBits[rd_addr[sliceOffset(i, ADDR_W) +: ADDR_W]]
                && !(wr_en && (wr_addr == rd_addr[sliceOffset(i, ADDR_W) +: ADDR_W]));
        end
    end

    assign rd_busy  = w_rdBusy;
    assign busy_cnt = r_busyCnt;

endmodule

// File: rtl/regfile_bypass.sv
// Multi-port register file with writeback bypass and pending-write tracking.
// Storage and the per-port read/bypass muxes live here; busy tracking is
// delegated to regfile_scoreboard.
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   rd_addr, rd_data  : packed read addresses / combinational read data
//   rd_busy           : per read port, addressed register has a pending write
//   wr_en, wr_addr,
//   wr_data           : writeback strobe, destination and value
//   iss_en, iss_addr  : issue strobe and destination
//   flush             : synchronous clear of all pending marks
//   busy_cnt          : registered count of pending registers
module regfile_bypass
    import regfile_bypass_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [NUM_RD*DATA_W-1:0] w_rdData;
    logic [ADDR_W-1:0]        w_portAddr;
    logic                     w_wrOk;

    // A writeback is only effective out of reset and away from the zero
    // register; the same qualifier gates the bypass so reads never see a
    // value that will not actually be stored.
    assign w_wrOk = wr_en && rst_n && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_mem[j] <= '0;
            end
        end else if (w_wrOk) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Each port independently resolves zero register, bypass, then storage.
    always_comb begin
        w_rdData   = '0;
        w_portAddr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_portAddr = rd_addr[sliceOffset(i, ADDR_W) +: ADDR_W];
            if ((ZERO_REG != 0) && (w_portAddr == '0)) begin
                w_rdData[sliceOffset(i, DATA_W) +: DATA_W] = '0;
            end else if (w_wrOk && (wr_addr == w_portAddr)) begin
                w_rdData[sliceOffset(i, DATA_W) +: DATA_W] = wr_data;
            end else begin
                w_rdData[sliceOffset(i, DATA_W) +: DATA_W] = r_mem[w_portAddr];
            end
        end
    end

    assign rd_data = w_rdData;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

endmodule
